dot_product_accumulator: RTL and testbench
==========================================

Name: dot_product_accumulator

Overview:
- Downstream consumer of the 32-bit pipelined Booth multiplier.
- Sums a stream of signed 64-bit products into groups (dot products) and delimits each group with a last flag.
- Saturates the sum to ACC_W bits and hands each group result to the next stage over a valid/ready handshake with a single output holding register.
- The upstream multiplier has no valid signal, so the control logic that issues operands also drives in_valid and in_last, aligned to the multiplier's product latency.

Parameters:
- PROD_W, 64: width of the signed product input.
- ACC_W, 72: width of the signed accumulator and result. Must be ≥ PROD_W+1.
- CNT_W, 8: width of the per-group term counter.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: a product beat is presented.
- in_last, input, 1: the beat is the final term of its group. Qualified by in_valid.
- product_i, input, PROD_W: signed product from the multiplier.
- in_ready, output, 1: the block can accept a beat this cycle.
- clear_i, input, 1: aborts the group in progress.
- out_valid, output, 1: the result register holds an undelivered group result.
- out_ready, input, 1: the downstream stage accepts the result.
- acc_o, output, ACC_W: signed group sum, saturated.
- cnt_o, output, CNT_W: number of terms in the group, saturating at 2^CNT_W-1.
- sat_o, output, 1: one or more additions in the group saturated.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - While rst=1 at a rising edge: state goes to IDLE, the running sum, count and sticky-saturation flag clear to 0, out_valid=0, acc_o=0, cnt_o=0, sat_o=0.
  - Reset in the middle of a group discards the partial group and any undelivered result.
- Handshakes:
  - A beat is accepted when in_valid && in_ready.
  - A result is delivered when out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready). Input stalls only when the result register is occupied and not being drained in the same cycle.
- State machine, two states:
  - IDLE: no partial group; the running sum is 0.
    - Accepted beat with in_last=0 → ACCUM.
    - Accepted beat with in_last=1 → single-term group completes; stay in IDLE.
  - ACCUM: partial group in progress.
    - Accepted beat with in_last=1 → IDLE, result is written.
    - clear_i → IDLE.
- Arithmetic:
  - The new sum is the running sum plus product_i sign-extended to ACC_W, computed at ACC_W+1 bits.
  - On positive overflow the sum clamps to 2^(ACC_W-1)-1; on negative overflow it clamps to -2^(ACC_W-1). Either case sets the sticky flag.
  - The count increments per accepted beat and holds at its maximum.
- Latency and result write:
  - On the accepted last beat, the final sum, count and sticky flag (all including that beat) load into acc_o, cnt_o and sat_o at the same edge.
  - out_valid=1 from the next cycle, i.e. 1-cycle latency from the last beat.
  - The running sum, count and sticky flag return to 0 at that same edge.
- Result register behaviour:
  - acc_o, cnt_o and sat_o hold stable while out_valid=1 && out_ready=0.
  - Delivery without a new result: out_valid → 0 next cycle; data outputs keep their last value.
  - Delivery and a new last beat in the same cycle: the new result loads and out_valid stays 1 (back-to-back, no bubble).
- clear_i:
  - Synchronous. Zeroes the running sum, count and sticky flag and returns to IDLE.
  - It has priority over a beat accepted in the same cycle; that beat is dropped, including a last beat.
  - It does not affect the output register or out_valid.
- Zero-length groups do not exist.
- in_last with in_valid=0 is ignored.

Test Plan:
- Single group: beats 200, 20, -450 (the last flagged) with out_ready=1 → one cycle after the last beat: out_valid=1, acc_o=-230, cnt_o=3, sat_o=0.
- Extreme product: a single beat 4611686014132420609 ((-2147483647)^2) with in_last=1 → acc_o=4611686014132420609, cnt_o=1, out_valid pulses for exactly one cycle.
- Saturation, with ACC_W=66: eight beats of 2^62 → acc_o=2^65-1, sat_o=1, cnt_o=8. The next group, a single beat -1, gives acc_o=-1, sat_o=0 (sticky flag cleared).
- Backpressure: hold out_ready=0 after the group -1, 1 completes, then send a second group → in_ready=0 and acc_o stays 0 until out_ready=1. Then the second result loads with no beat lost.
- Back-to-back: single-term groups 2147483647 and -2147483647 on consecutive cycles with out_ready=1 → out_valid stays high for 2 cycles, acc_o shows 2147483647 then -2147483647.
- Clear and reset: beats 5, 7, then clear_i with a last beat of 9 in the same cycle, then a single-term group 3 → the only result is acc_o=3, cnt_o=1. Asserting rst in the middle of a group → all outputs are 0 next cycle.

Source files
------------

// File: rtl/dot_product_accumulator_if.sv
// dot_product_accumulator_if: signed product stream in, saturated group result out
interface dot_product_accumulator_if #(
  parameter int PROD_W = 64,
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
);
  logic in_valid;
  logic in_last;
  logic signed [PROD_W-1:0] product_i;
  logic in_ready;
  logic clear_i;
  logic out_valid;
  logic out_ready;
  logic signed [ACC_W-1:0] acc_o;
  logic [CNT_W-1:0] cnt_o;
  logic sat_o;
  modport master (
    output in_valid, in_last, product_i, clear_i, out_ready,
    input in_ready, out_valid, acc_o, cnt_o, sat_o
  );
  modport slave (
    input in_valid, in_last, product_i, clear_i, out_ready,
    output in_ready, out_valid, acc_o, cnt_o, sat_o
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: sums signed product groups with saturation into a handshaked result register
module dot_product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  dot_product_accumulator_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nx;
  logic signed [ACC_W-1:0] sum, sum_nx, sat_sum;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic sat, sat_nx, sat_new;
  logic [ACC_W:0] wide;
  logic take, fin, ovp, ovn;
  assign bus.in_ready = !(bus.out_valid && !bus.out_ready);
  assign take = bus.in_valid && bus.in_ready && !bus.clear_i;
  assign fin = take && bus.in_last;
  assign wide = {sum[ACC_W-1], sum} + {{(ACC_W+1-PROD_W){bus.product_i[PROD_W-1]}}, bus.product_i};
  assign ovp = !wide[ACC_W] && wide[ACC_W-1];
  assign ovn = wide[ACC_W] && !wide[ACC_W-1];
  assign sat_sum = ovp ? {1'b0, {(ACC_W-1){1'b1}}} : ovn ? {1'b1, {(ACC_W-1){1'b0}}} : wide[ACC_W-1:0];
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign sat_new = sat || ovp || ovn;
  // running group state: clear or a finished group zeroes it, any other accepted beat accumulates
  always_comb begin
    state_nx = state;
    sum_nx = sum;
    cnt_nx = cnt;
    sat_nx = sat;
    if (bus.clear_i || fin) begin
      state_nx = IDLE;
      sum_nx = '0;
      cnt_nx = '0;
      sat_nx = 1'b0;
    end else if (take) begin
      state_nx = ACCUM;
      sum_nx = sat_sum;
      cnt_nx = cnt_inc;
      sat_nx = sat_new;
    end
  end
  // state and running accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      state <= state_nx;
      sum <= sum_nx;
      cnt <= cnt_nx;
      sat <= sat_nx;
    end
  end
  // result holding register: loads on a last beat, drains on delivery, data held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.acc_o <= '0;
      bus.cnt_o <= '0;
      bus.sat_o <= 1'b0;
    end else if (fin) begin
      bus.out_valid <= 1'b1;
      bus.acc_o <= sat_sum;
      bus.cnt_o <= cnt_inc;
      bus.sat_o <= sat_new;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb_dot_product_accumulator: directed vectors with a scoreboard checked on each result delivery
module tb_dot_product_accumulator;
  typedef struct {
    logic signed [65:0] acc;
    logic [7:0] cnt;
    logic sat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  dot_product_accumulator_if #(.PROD_W(64), .ACC_W(66), .CNT_W(8)) bus ();
  dot_product_accumulator #(.PROD_W(64), .ACC_W(66), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic signed [65:0] act, input logic signed [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push(input logic signed [65:0] acc, input logic [7:0] cnt, input logic sat);
    exp_t e;
    e.acc = acc;
    e.cnt = cnt;
    e.sat = sat;
    sb.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic signed [63:0] p, input logic last);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_last = last;
    bus.product_i = p;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.in_ready;
      cyc();
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL beat_accept: got in_ready 0 expected 1 within 20 cycles");
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  // monitor: every delivered result is compared against the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got acc %0d expected no result", bus.acc_o);
        end else begin
          e = sb.pop_front();
          chk("sb_acc", bus.acc_o, e.acc);
          chk("sb_cnt", bus.cnt_o, e.cnt);
          chk("sb_sat", bus.sat_o, e.sat);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.product_i = '0;
    bus.clear_i = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) cyc();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_acc", bus.acc_o, 0);
    chk("rst_cnt", bus.cnt_o, 0);
    chk("rst_sat", bus.sat_o, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    cyc();
    push(-230, 3, 0);
    beat(200, 0);
    beat(20, 0);
    beat(-450, 1);
    chk("grp_out_valid", bus.out_valid, 1);
    chk("grp_acc", bus.acc_o, -230);
    cyc();
    push(66'sd4611686014132420609, 1, 0);
    beat(64'sd4611686014132420609, 1);
    chk("ext_valid_hi", bus.out_valid, 1);
    cyc();
    chk("ext_valid_pulse", bus.out_valid, 0);
    push({1'b0, {65{1'b1}}}, 8, 1);
    for (int i = 0; i < 8; i++) beat(64'sh4000_0000_0000_0000, i == 7);
    chk("sat_flag", bus.sat_o, 1);
    push(-1, 1, 0);
    beat(-1, 1);
    chk("sat_cleared", bus.sat_o, 0);
    cyc();
    bus.out_ready = 1'b0;
    push(0, 2, 0);
    beat(-1, 0);
    beat(1, 1);
    push(30, 2, 0);
    bus.in_valid = 1'b1;
    bus.in_last = 1'b0;
    bus.product_i = 10;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_acc_hold", bus.acc_o, 0);
      chk("bp_valid_hold", bus.out_valid, 1);
      cyc();
    end
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    beat(20, 1);
    chk("bp_second_acc", bus.acc_o, 30);
    cyc();
    push(2147483647, 1, 0);
    push(-2147483647, 1, 0);
    beat(2147483647, 1);
    chk("b2b_valid_1", bus.out_valid, 1);
    chk("b2b_acc_1", bus.acc_o, 2147483647);
    beat(-2147483647, 1);
    chk("b2b_valid_2", bus.out_valid, 1);
    chk("b2b_acc_2", bus.acc_o, -2147483647);
    cyc();
    chk("b2b_valid_end", bus.out_valid, 0);
    beat(5, 0);
    beat(7, 0);
    bus.in_valid = 1'b1;
    bus.in_last = 1'b1;
    bus.product_i = 9;
    bus.clear_i = 1'b1;
    cyc();
    bus.clear_i = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    chk("clr_drop_last", bus.out_valid, 0);
    push(3, 1, 0);
    beat(3, 1);
    chk("clr_cnt", bus.cnt_o, 1);
    cyc();
    beat(100, 0);
    beat(50, 0);
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_acc", bus.acc_o, 0);
    chk("mid_rst_cnt", bus.cnt_o, 0);
    chk("mid_rst_sat", bus.sat_o, 0);
    rst = 1'b0;
    push(4, 1, 0);
    beat(4, 1);
    repeat (3) cyc();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
